// File: rtl/cpu_regfile_mp_sb_if.sv
// Bundles the decode/write-back facing signals of the register bank so that
// read, write-back and reservation traffic travel together as one port.
interface cpu_regfile_mp_sb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 2
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int CW = $clog2(NUM_REGS + 1);

    logic [NUM_RD*AW-1:0]         rd_addr;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]            rd_busy;
    logic [NUM_WR-1:0]            wr_en;
    logic [NUM_WR*AW-1:0]         wr_addr;
    logic [NUM_WR*DATA_WIDTH-1:0] wr_data;
    logic                         rsv_en;
    logic [AW-1:0]                rsv_addr;
    logic                         rsv_grant;
    logic                         flush;
    logic                         wr_conflict;
    logic [CW-1:0]                busy_cnt;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
        input  rd_data, rd_busy, rsv_grant, wr_conflict, busy_cnt
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
        output rd_data, rd_busy, rsv_grant, wr_conflict, busy_cnt
    );
endinterface

// File: rtl/cpu_regfile_mp_sb.sv
// Multi-port register bank with a busy-bit scoreboard so decode can stall
// on reads of, or reservations against, registers with writes in flight.
module cpu_regfile_mp_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 2,
    parameter bit BYPASS     = 1'b1,
    parameter bit ZERO_REG   = 1'b0
) (
    input logic                clock,
    input logic                reset,
    cpu_regfile_mp_sb_if.slave bus
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int CW = $clog2(NUM_REGS + 1);

    logic [DATA_WIDTH-1:0] regs    [NUM_REGS];
    logic [DATA_WIDTH-1:0] wb_data [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busy_next;
    logic [NUM_REGS-1:0]   wb_hit;
    logic [AW-1:0]         wa;
    logic [AW-1:0]         ra;
    logic                  conflict_now;
    logic                  grant;
    logic [CW-1:0]         cnt_next;
    logic                  wr_conflict_q;
    logic [CW-1:0]         busy_cnt_q;

    // Ports are scanned in ascending order so a higher-index port overwrites a lower one.
    always_comb begin
        wb_hit       = '0;
        conflict_now = 1'b0;
        wa           = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            wb_data[r] = '0;
        end
        for (int w = 0; w < NUM_WR; w++) begin
            wa = bus.wr_addr[w*AW +: AW];
            if (bus.wr_en[w]) begin
                if (wb_hit[wa]) begin
                    conflict_now = 1'b1;
                end
                wb_hit[wa]  = 1'b1;
                wb_data[wa] = bus.wr_data[w*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        ra          = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra = bus.rd_addr[i*AW +: AW];
            if (!(ZERO_REG && ra == '0)) begin
                if (BYPASS && wb_hit[ra]) begin
                    bus.rd_data[i*DATA_WIDTH +: DATA_WIDTH] = wb_data[ra];
                end else begin
                    bus.rd_data[i*DATA_WIDTH +: DATA_WIDTH] = regs[ra];
                end
                bus.rd_busy[i] = busy[ra] & ~(BYPASS & wb_hit[ra]);
            end
        end
    end

    // A same-cycle write-back frees the register, so a new reservation may take it over.
    always_comb begin
        grant     = bus.rsv_en & ~bus.flush & (~busy[bus.rsv_addr] | wb_hit[bus.rsv_addr]);
        busy_next = busy & ~wb_hit;
        if (grant && !(ZERO_REG && bus.rsv_addr == '0)) begin
            busy_next[bus.rsv_addr] = 1'b1;
        end
        if (bus.flush) begin
            busy_next = '0;
        end
        cnt_next = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_next = cnt_next + CW'(busy_next[r]);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
            busy          <= '0;
            wr_conflict_q <= 1'b0;
            busy_cnt_q    <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (wb_hit[r] && !(ZERO_REG && r == 0)) begin
                    regs[r] <= wb_data[r];
                end
            end
            busy          <= busy_next;
            wr_conflict_q <= conflict_now;
            busy_cnt_q    <= cnt_next;
        end
    end

    assign bus.rsv_grant   = grant;
    assign bus.wr_conflict = wr_conflict_q;
    assign bus.busy_cnt    = busy_cnt_q;
endmodule

// File: tb/tb_cpu_regfile_mp_sb.sv
// Bench for cpu_regfile_mp_sb: one instance with forwarding, one with a hardwired
// zero register, both driven identically and compared against an array-based model.
module tb_cpu_regfile_mp_sb;
    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 5;
    localparam int CW = 6;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    cpu_regfile_mp_sb_if #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RD(2), .NUM_WR(2)) bus0 ();
    cpu_regfile_mp_sb_if #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RD(2), .NUM_WR(2)) bus1 ();

    cpu_regfile_mp_sb #(
        .DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RD(2), .NUM_WR(2),
        .BYPASS(1'b1), .ZERO_REG(1'b0)
    ) dut0 (.clock(clock), .reset(reset), .bus(bus0));

    cpu_regfile_mp_sb #(
        .DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RD(2), .NUM_WR(2),
        .BYPASS(1'b0), .ZERO_REG(1'b1)
    ) dut1 (.clock(clock), .reset(reset), .bus(bus1));

    logic [1:0]    s_we;
    logic [AW-1:0] s_wa [2];
    logic [DW-1:0] s_wd [2];
    logic          s_rsv;
    logic [AW-1:0] s_rsv_a;
    logic          s_flush;
    logic [AW-1:0] s_ra [2];

    logic [DW-1:0] m_mem  [2][NR];
    bit            m_busy [2][NR];
    bit            m_conf [2];
    int            m_cnt  [2];

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [1:0]    we;
        logic [AW-1:0] wa0;
        logic [DW-1:0] wd0;
        logic [AW-1:0] wa1;
        logic [DW-1:0] wd1;
        logic          rsv;
        logic [AW-1:0] rsv_a;
        logic          fl;
        logic [AW-1:0] rd;
        logic [DW-1:0] e_rd;
        logic          e_busy;
        logic          e_grant;
        logic [CW-1:0] e_cnt;
        logic          e_conf;
    } vec_t;

    vec_t tbl [14];

    function automatic bit is_byp(int k);
        return k == 0;
    endfunction

    function automatic bit has_zero(int k);
        return k == 1;
    endfunction

    // Highest-numbered enabled port targeting address a, or -1 if none.
    function automatic int last_writer(int a);
        for (int w = 1; w >= 0; w--) begin
            if (s_we[w] && int'(s_wa[w]) == a) return w;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] exp_read(int k, int a);
        int w;
        w = last_writer(a);
        if (has_zero(k) && a == 0) return '0;
        if (is_byp(k) && w >= 0) return s_wd[w];
        return m_mem[k][a];
    endfunction

    function automatic bit exp_rbusy(int k, int a);
        if (has_zero(k) && a == 0) return 1'b0;
        return m_busy[k][a] && !(is_byp(k) && last_writer(a) >= 0);
    endfunction

    function automatic bit exp_grant(int k);
        return s_rsv && !s_flush && (!m_busy[k][s_rsv_a] || last_writer(int'(s_rsv_a)) >= 0);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < NR; a++) begin
                m_mem[k][a]  = '0;
                m_busy[k][a] = 1'b0;
            end
            m_conf[k] = 1'b0;
            m_cnt[k]  = 0;
        end
    endtask

    task automatic model_commit();
        bit g;
        int w;
        for (int k = 0; k < 2; k++) begin
            g = exp_grant(k);
            for (int a = 0; a < NR; a++) begin
                w = last_writer(a);
                if (w >= 0) begin
                    if (!(has_zero(k) && a == 0)) m_mem[k][a] = s_wd[w];
                    m_busy[k][a] = 1'b0;
                end
            end
            if (g && !(has_zero(k) && s_rsv_a == '0)) m_busy[k][s_rsv_a] = 1'b1;
            if (s_flush) begin
                for (int a = 0; a < NR; a++) m_busy[k][a] = 1'b0;
            end
            m_conf[k] = (s_we == 2'b11) && (s_wa[0] == s_wa[1]);
            m_cnt[k]  = 0;
            for (int a = 0; a < NR; a++) m_cnt[k] += int'(m_busy[k][a]);
        end
    endtask

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic apply_stimulus();
        bus0.wr_en    = s_we;
        bus0.wr_addr  = {s_wa[1], s_wa[0]};
        bus0.wr_data  = {s_wd[1], s_wd[0]};
        bus0.rsv_en   = s_rsv;
        bus0.rsv_addr = s_rsv_a;
        bus0.flush    = s_flush;
        bus0.rd_addr  = {s_ra[1], s_ra[0]};
        bus1.wr_en    = s_we;
        bus1.wr_addr  = {s_wa[1], s_wa[0]};
        bus1.wr_data  = {s_wd[1], s_wd[0]};
        bus1.rsv_en   = s_rsv;
        bus1.rsv_addr = s_rsv_a;
        bus1.flush    = s_flush;
        bus1.rd_addr  = {s_ra[1], s_ra[0]};
    endtask

    task automatic set_idle();
        s_we    = 2'b00;
        s_wa[0] = '0;
        s_wa[1] = '0;
        s_wd[0] = '0;
        s_wd[1] = '0;
        s_rsv   = 1'b0;
        s_rsv_a = '0;
        s_flush = 1'b0;
        s_ra[0] = '0;
        s_ra[1] = '0;
    endtask

    task automatic pre_edge(input bit do_check);
        logic [DW-1:0] act_d;
        logic          act_b;
        logic          act_g;
        apply_stimulus();
        #1;
        if (do_check) begin
            for (int k = 0; k < 2; k++) begin
                for (int p = 0; p < 2; p++) begin
                    act_d = (k == 0) ? bus0.rd_data[p*DW +: DW] : bus1.rd_data[p*DW +: DW];
                    act_b = (k == 0) ? bus0.rd_busy[p] : bus1.rd_busy[p];
                    check_output($sformatf("inst%0d rd_data[%0d] a=%0d", k, p, s_ra[p]),
                                 64'(act_d), 64'(exp_read(k, int'(s_ra[p]))));
                    check_output($sformatf("inst%0d rd_busy[%0d] a=%0d", k, p, s_ra[p]),
                                 64'(act_b), 64'(exp_rbusy(k, int'(s_ra[p]))));
                end
                act_g = (k == 0) ? bus0.rsv_grant : bus1.rsv_grant;
                check_output($sformatf("inst%0d rsv_grant", k), 64'(act_g), 64'(exp_grant(k)));
            end
        end
    endtask

    task automatic post_edge(input bit do_check);
        @(posedge clock);
        if (!reset) model_reset();
        else model_commit();
        #1;
        if (do_check) begin
            check_output("inst0 wr_conflict", 64'(bus0.wr_conflict), 64'(m_conf[0]));
            check_output("inst1 wr_conflict", 64'(bus1.wr_conflict), 64'(m_conf[1]));
            check_output("inst0 busy_cnt", 64'(bus0.busy_cnt), 64'(m_cnt[0]));
            check_output("inst1 busy_cnt", 64'(bus1.busy_cnt), 64'(m_cnt[1]));
        end
    endtask

    initial begin
        tbl[0]  = '{2'b11, 5'd5, 32'h11, 5'd5, 32'h22, 1'b0, 5'd0, 1'b0, 5'd5, 32'h22, 1'b0, 1'b0, 6'd0, 1'b1};
        tbl[1]  = '{2'b00, 5'd0, 32'h0,  5'd0, 32'h0,  1'b0, 5'd0, 1'b0, 5'd5, 32'h22, 1'b0, 1'b0, 6'd0, 1'b0};
        tbl[2]  = '{2'b00, 5'd0, 32'h0,  5'd0, 32'h0,  1'b1, 5'd3, 1'b0, 5'd3, 32'h0,  1'b0, 1'b1, 6'd1, 1'b0};
        tbl[3]  = '{2'b00, 5'd0, 32'h0,  5'd0, 32'h0,  1'b1, 5'd3, 1'b0, 5'd3, 32'h0,  1'b1, 1'b0, 6'd1, 1'b0};
        tbl[4]  = '{2'b01, 5'd3, 32'hAB, 5'd0, 32'h0,  1'b0, 5'd0, 1'b0, 5'd3, 32'hAB, 1'b0, 1'b0, 6'd0, 1'b0};
        tbl[5]  = '{2'b00, 5'd0, 32'h0,  5'd0, 32'h0,  1'b0, 5'd0, 1'b0, 5'd3, 32'hAB, 1'b0, 1'b0, 6'd0, 1'b0};
        tbl[6]  = '{2'b00, 5'd0, 32'h0,  5'd0, 32'h0,  1'b1, 5'd7, 1'b0, 5'd7, 32'h0,  1'b0, 1'b1, 6'd1, 1'b0};
        tbl[7]  = '{2'b10, 5'd0, 32'h0,  5'd7, 32'h77, 1'b1, 5'd7, 1'b0, 5'd7, 32'h77, 1'b0, 1'b1, 6'd1, 1'b0};
        tbl[8]  = '{2'b00, 5'd0, 32'h0,  5'd0, 32'h0,  1'b0, 5'd0, 1'b0, 5'd7, 32'h77, 1'b1, 1'b0, 6'd1, 1'b0};
        tbl[9]  = '{2'b00, 5'd0, 32'h0,  5'd0, 32'h0,  1'b1, 5'd1, 1'b0, 5'd7, 32'h77, 1'b1, 1'b1, 6'd2, 1'b0};
        tbl[10] = '{2'b00, 5'd0, 32'h0,  5'd0, 32'h0,  1'b1, 5'd2, 1'b0, 5'd7, 32'h77, 1'b1, 1'b1, 6'd3, 1'b0};
        tbl[11] = '{2'b00, 5'd0, 32'h0,  5'd0, 32'h0,  1'b1, 5'd4, 1'b0, 5'd7, 32'h77, 1'b1, 1'b1, 6'd4, 1'b0};
        tbl[12] = '{2'b00, 5'd0, 32'h0,  5'd0, 32'h0,  1'b1, 5'd6, 1'b1, 5'd6, 32'h0,  1'b0, 1'b0, 6'd0, 1'b0};
        tbl[13] = '{2'b00, 5'd0, 32'h0,  5'd0, 32'h0,  1'b0, 5'd0, 1'b0, 5'd7, 32'h77, 1'b0, 1'b0, 6'd0, 1'b0};

        // Reset held with both write ports colliding; reset must win.
        reset = 1'b0;
        set_idle();
        s_we    = 2'b11;
        s_wa[0] = 5'd9;
        s_wa[1] = 5'd9;
        s_wd[0] = 32'hDEAD_0001;
        s_wd[1] = 32'hDEAD_0002;
        s_rsv   = 1'b1;
        s_rsv_a = 5'd9;
        for (int c = 0; c < 2; c++) begin
            pre_edge(1'b0);
            post_edge(1'b0);
        end
        check_output("reset wr_conflict", 64'(bus0.wr_conflict), 64'd0);
        check_output("reset busy_cnt", 64'(bus0.busy_cnt), 64'd0);
        reset = 1'b1;
        set_idle();
        for (int a = 0; a < NR; a += 2) begin
            s_ra[0] = AW'(a);
            s_ra[1] = AW'(a + 1);
            pre_edge(1'b1);
            check_output($sformatf("reset rd_data r%0d", a), 64'(bus0.rd_data), 64'd0);
            post_edge(1'b1);
        end

        for (int i = 0; i < 14; i++) begin
            s_we    = tbl[i].we;
            s_wa[0] = tbl[i].wa0;
            s_wd[0] = tbl[i].wd0;
            s_wa[1] = tbl[i].wa1;
            s_wd[1] = tbl[i].wd1;
            s_rsv   = tbl[i].rsv;
            s_rsv_a = tbl[i].rsv_a;
            s_flush = tbl[i].fl;
            s_ra[0] = tbl[i].rd;
            s_ra[1] = tbl[i].rd ^ 5'd1;
            pre_edge(1'b1);
            check_output($sformatf("vec%0d rd_data", i), 64'(bus0.rd_data[DW-1:0]), 64'(tbl[i].e_rd));
            check_output($sformatf("vec%0d rd_busy", i), 64'(bus0.rd_busy[0]), 64'(tbl[i].e_busy));
            check_output($sformatf("vec%0d rsv_grant", i), 64'(bus0.rsv_grant), 64'(tbl[i].e_grant));
            post_edge(1'b1);
            check_output($sformatf("vec%0d busy_cnt", i), 64'(bus0.busy_cnt), 64'(tbl[i].e_cnt));
            check_output($sformatf("vec%0d wr_conflict", i), 64'(bus0.wr_conflict), 64'(tbl[i].e_conf));
        end

        // Hardwired zero register: write and reserve of r0 leave no trace.
        set_idle();
        s_we    = 2'b01;
        s_wa[0] = 5'd0;
        s_wd[0] = 32'h0000_FFFF;
        s_rsv   = 1'b1;
        s_rsv_a = 5'd0;
        pre_edge(1'b1);
        check_output("zero rd_data", 64'(bus1.rd_data[DW-1:0]), 64'd0);
        check_output("zero rd_busy", 64'(bus1.rd_busy[0]), 64'd0);
        check_output("zero rsv_grant", 64'(bus1.rsv_grant), 64'd1);
        post_edge(1'b1);
        check_output("zero busy_cnt", 64'(bus1.busy_cnt), 64'd0);
        set_idle();
        pre_edge(1'b1);
        check_output("zero rd_data after", 64'(bus1.rd_data[DW-1:0]), 64'd0);
        check_output("zero rd_busy after", 64'(bus1.rd_busy[0]), 64'd0);
        post_edge(1'b1);

        // Random traffic over a narrow address window to provoke hazards.
        for (int c = 0; c < 400; c++) begin
            s_we    = 2'($urandom_range(0, 3));
            s_wa[0] = AW'($urandom_range(0, 7));
            s_wa[1] = AW'($urandom_range(0, 7));
            s_wd[0] = $urandom;
            s_wd[1] = $urandom;
            s_rsv   = 1'($urandom_range(0, 1));
            s_rsv_a = AW'($urandom_range(0, 7));
            s_flush = ($urandom_range(0, 15) == 0);
            s_ra[0] = AW'($urandom_range(0, 7));
            s_ra[1] = AW'($urandom_range(0, 7));
            pre_edge(1'b1);
            post_edge(1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
